// File: rtl/hdlverifier_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hdlverifier_capture_ctrl
//  Brief    : Capture controller for the JTAG capture core. It decodes host
//             register writes, runs a circular sample buffer through
//             pre-fill, trigger wait, post-fill and DONE, and streams the
//             buffer oldest-first as serial bits through a RAM that has one
//             cycle of read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module hdlverifier_capture_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  tck,
    input  logic                  reset,
    input  logic [4:0]            reg_addr,
    input  logic [31:0]           reg_wdata,
    input  logic                  reg_write,
    output logic [31:0]           reg_rdata,
    input  logic                  shift_out_state,
    input  logic                  shift_out_en,
    output logic                  shift_out_data,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  buf_wen,
    output logic [ADDR_WIDTH-1:0] buf_waddr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic [ADDR_WIDTH-1:0] buf_raddr,
    input  logic [DATA_WIDTH-1:0] buf_rdata
);

    localparam int                  DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_POST_RST = (ADDR_WIDTH+1)'(DEPTH / 2);
    localparam logic [ADDR_WIDTH:0] c_CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [5:0]          c_LAST_BIT = 6'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFILL   = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]     post_q, post_d;
    logic [DATA_WIDTH-1:0]   trig_val_q, trig_val_d;
    logic [DATA_WIDTH-1:0]   trig_mask_q, trig_mask_d;
    logic [ADDR_WIDTH-1:0]   start_q, start_d;
    logic                    buf_wen_q, buf_wen_d;
    logic [ADDR_WIDTH-1:0]   buf_waddr_q, buf_waddr_d;
    logic [DATA_WIDTH-1:0]   buf_wdata_q, buf_wdata_d;

    logic                    sos_q, sos_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]              load_q, load_d;
    logic [5:0]              bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    sod_q, sod_d;

    logic                    w_cmd_wr;
    logic                    w_capturing;
    logic                    w_trig_hit;
    logic [ADDR_WIDTH:0]     w_cnt_inc;
    logic [ADDR_WIDTH:0]     w_prefill_n;
    logic                    w_rise;

    assign w_cmd_wr    = reg_write && (reg_addr == 5'd0);
    assign w_capturing = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    assign w_trig_hit  = ((data_in ^ trig_val_q) & trig_mask_q) == '0;
    assign w_cnt_inc   = cnt_q + c_CNT_ONE;
    assign w_prefill_n = c_DEPTH - post_q;
    assign w_rise      = shift_out_state && !sos_q;

    assign buf_wen        = buf_wen_q;
    assign buf_waddr      = buf_waddr_q;
    assign buf_wdata      = buf_wdata_q;
    assign buf_raddr      = rd_ptr_q;
    assign shift_out_data = sod_q;

    // Capture sequencing and host configuration: commands pre-empt sample handling
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        post_d      = post_q;
        trig_val_d  = trig_val_q;
        trig_mask_d = trig_mask_q;
        start_d     = start_q;
        buf_wen_d   = 1'b0;
        buf_waddr_d = buf_waddr_q;
        buf_wdata_d = buf_wdata_q;

        if (w_cmd_wr && reg_wdata[1]) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end else if (w_cmd_wr && reg_wdata[0]) begin
            wr_ptr_d = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
            // A full-depth post window leaves nothing to pre-fill
            state_d  = (post_q == c_DEPTH) ? S_WAIT_TRIG : S_PREFILL;
        end else if (data_valid && w_capturing) begin
            buf_wen_d   = 1'b1;
            buf_waddr_d = wr_ptr_q;
            buf_wdata_d = data_in;
            wr_ptr_d    = wr_ptr_q + c_PTR_ONE;
            case (state_q)
                S_PREFILL: begin
                    if (w_cnt_inc == w_prefill_n) begin
                        state_d = S_WAIT_TRIG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
                S_WAIT_TRIG: begin
                    if (w_trig_hit) begin
                        cnt_d = c_CNT_ONE;
                        if (post_q == c_CNT_ONE) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            start_d = wr_ptr_d;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
                S_POST: begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == post_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        start_d = wr_ptr_d;
                    end
                end
                default: begin
                end
            endcase
        end

        if (reg_write) begin
            case (reg_addr)
                5'd2: begin
                    if (reg_wdata == 32'd0) begin
                        post_d = c_CNT_ONE;
                    end else if (reg_wdata > 32'(DEPTH)) begin
                        post_d = c_DEPTH;
                    end else begin
                        post_d = reg_wdata[ADDR_WIDTH:0];
                    end
                end
                5'd4:    trig_val_d  = reg_wdata[DATA_WIDTH-1:0];
                5'd5:    trig_mask_d = reg_wdata[DATA_WIDTH-1:0];
                default: begin
                end
            endcase
        end
    end

    // Serial readout: two-cycle initial fetch, then one bit per enable with
    // the next word prefetched as soon as the current one is loaded
    always_comb begin
        sos_d    = shift_out_state;
        rd_ptr_d = rd_ptr_q;
        load_d   = load_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        sod_d    = sod_q;

        if (!shift_out_state) begin
            load_d = 2'd0;
        end else if (w_rise) begin
            rd_ptr_d = start_q;
            load_d   = 2'd2;
            bit_d    = '0;
        end else if (load_q == 2'd2) begin
            load_d = 2'd1;
        end else if (load_q == 2'd1) begin
            shreg_d  = buf_rdata;
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            load_d   = 2'd0;
            bit_d    = '0;
        end else if (shift_out_en) begin
            sod_d = shreg_q[0];
            if (bit_q == c_LAST_BIT) begin
                shreg_d  = buf_rdata;
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
                bit_d    = '0;
            end else begin
                shreg_d = shreg_q >> 1;
                bit_d   = bit_q + 6'd1;
            end
        end
    end

    // Combinational register read mux
    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            5'd1: begin
                reg_rdata[2:0] = state_q;
                reg_rdata[3]   = done_q;
            end
            5'd2:    reg_rdata = 32'(post_q);
            5'd3:    reg_rdata = 32'(DEPTH);
            5'd4:    reg_rdata = 32'(trig_val_q);
            5'd5:    reg_rdata = 32'(trig_mask_q);
            5'd6:    reg_rdata = 32'(start_q);
            default: reg_rdata = 32'd0;
        endcase
    end

    // State register for capture and readout
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            post_q      <= c_POST_RST;
            trig_val_q  <= '0;
            trig_mask_q <= '0;
            start_q     <= '0;
            buf_wen_q   <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
            sos_q       <= 1'b0;
            rd_ptr_q    <= '0;
            load_q      <= 2'd0;
            bit_q       <= '0;
            shreg_q     <= '0;
            sod_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            post_q      <= post_d;
            trig_val_q  <= trig_val_d;
            trig_mask_q <= trig_mask_d;
            start_q     <= start_d;
            buf_wen_q   <= buf_wen_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
            sos_q       <= sos_d;
            rd_ptr_q    <= rd_ptr_d;
            load_q      <= load_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            sod_q       <= sod_d;
        end
    end

endmodule
`default_nettype wire
